// File: rtl/tap_serializer.sv
// Queues tap sets captured on each rising edge of found and streams them out
// MSB-first over the dout/take/done bit-serial protocol.
module tap_serializer #(
    parameter int NUM_OF_TAPS = 15,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     found,
    input  logic [NUM_OF_TAPS*8-1:0] taps,
    input  logic                     ena,
    output logic                     dout,
    output logic                     take,
    output logic                     done,
    output logic                     busy,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int TAPS_W = NUM_OF_TAPS * 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int BIT_W  = $clog2(TAPS_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic              found_q;
    logic [TAPS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TAPS_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;

    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic empty;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    always_comb begin
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
        push_req = found & ~found_q;
        pop      = (state == IDLE) & ~empty;
        push     = push_req & (~full | pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= taps;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state    <= IDLE;
            found_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            dout     <= 1'b0;
            take     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            found_q  <= found;
            overflow <= push_req & ~push;
            busy     <= (state == SHIFT) | ~empty;
            if (push_req & ~push) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    take <= 1'b0;
                    done <= 1'b0;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= BIT_W'(TAPS_W - 1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ena) begin
                        dout    <= shreg[TAPS_W-1];
                        take    <= 1'b1;
                        shreg   <= {shreg[TAPS_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - BIT_W'(1);
                        if (bit_cnt == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            done <= 1'b0;
                        end
                    end else begin
                        take <= 1'b0;
                        done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tap_serializer.md
Name: tap_serializer

Overview:
- Reporting end of the search path: captures the tap set (`co_buf` word) each time the NLFSR search asserts `found`, queues it, and streams it out bit-serially.
- Uses the same `dout` / `take` / `done` bit-stream protocol that the selector consumes from the PRNG. This block is the transmitter side of that protocol.
- Sits between the search module and the external result collector.
- Absorbs bursts of finds with a small FIFO and counts results dropped on overflow.

Parameters:
- NUM_OF_TAPS, 15, number of 8-bit tap fields; frame width TAPS_W = NUM_OF_TAPS*8 (120 by default).
- DEPTH, 4, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- found  in  1  search success level from the NLFSR (may stay high for many cycles).
- taps  in  NUM_OF_TAPS*8  tap vector under test, valid whenever found is high.
- ena  in  1  consumer permits one bit per cycle while high.
- dout  out  1  serial data, MSB of the frame first.
- take  out  1  dout valid this cycle.
- done  out  1  high together with take on the last bit of a frame.
- busy  out  1  frame in progress or FIFO not empty.
- overflow  out  1  one-cycle pulse when a capture is dropped.
- drop_cnt  out  8  saturating count of dropped captures.

Behaviour:
- Reset (res=0, asynchronous):
  - FIFO emptied, state IDLE, shift register 0, bit counter 0, found_q 0.
  - dout=0, take=0, done=0, busy=0, overflow=0, drop_cnt=0.
  - Takes effect mid-frame; the partial frame is abandoned and never resumed.
- Capture:
  - Push on the rising edge of found only (found & ~found_q, with found_q registered), sampling taps on that same clk edge.
  - A level held high produces exactly one push.
- Overflow:
  - If the FIFO is full and no pop occurs that cycle, the capture is discarded.
  - overflow=1 for one cycle; drop_cnt increments, saturating at 255.
  - If full and a pop occurs in the same cycle, the push is accepted and counts are unchanged.
- All outputs are registered.
- FSM, state IDLE:
  - take=0, done=0.
  - If the FIFO is not empty: pop the head into the shift register, bit counter <= TAPS_W-1, go to SHIFT.
  - Push and pop in the same cycle on a non-full FIFO: both occur, occupancy unchanged.
- FSM, state SHIFT, at each edge:
  - ena=1: dout <= shreg[TAPS_W-1], take <= 1, shreg shifts left by 1, counter decrements.
    - If the counter was 0: done <= 1 and go to IDLE.
  - ena=0: take <= 0, done <= 0; dout, shreg and counter hold.
- Latency and framing:
  - found rises and is sampled at edge N. Load at edge N+1. First bit (take=1) visible after edge N+2 if ena=1.
  - Frame length is exactly TAPS_W take-pulses.
  - Back-to-back frames are separated by exactly one take=0 cycle (the IDLE load cycle).
- busy = (state==SHIFT) | (FIFO not empty), registered.
- FIFO order is strict first-in first-out; read/write pointers wrap modulo DEPTH.
- A full/empty ambiguity at wrap is resolved with an explicit occupancy counter of width clog2(DEPTH)+1.
- taps changing while found stays high has no effect after the capture edge.

Test Plan:
- Single capture:
  - Stimulus: reset, ena=1, taps = {8'hA5, 112'h0}, found pulsed at edge 10.
  - Required: take first high after edge 12, first 8 dout bits 1,0,1,0,0,1,0,1, then 112 zeros.
  - done high only on take #120 (after edge 131); busy low after edge 132.
- Backpressure:
  - Stimulus: same frame with ena toggling 1,0,1,0,...
  - Required: exactly 120 take pulses; no bit skipped or repeated (compare the reassembled 120-bit word with taps); done on the last one.
- Burst and ordering:
  - Stimulus: 3 found pulses 2 cycles apart with taps = 120'h1, 120'h2, 120'h3, ena=1.
  - Required: three frames in that order; exactly one take=0 cycle between frames; overflow never asserted.
- Overflow:
  - Stimulus: ena=0; 6 found rising edges with distinct taps.
  - Required: first at IDLE loads the shifter; 4 fill the FIFO; the 6th drops (overflow pulse, drop_cnt=1).
  - Then ena=1: 5 frames emitted in capture order.
  - 300 further dropped captures leave drop_cnt=255.
- Level found:
  - Stimulus: found held high for 500 cycles.
  - Required: exactly one frame emitted, drop_cnt=0.
- Reset mid-frame:
  - Stimulus: res=0 asynchronously after take #50 of a frame, with 2 entries queued.
  - Required: take/done/busy 0 immediately, before the next clk edge. After release, no frame is emitted until a new found edge arrives.
